// File: rtl/el_latch_ctrl.sv
// -----------------------------------------------------------------------------
// el_latch_ctrl
//   Clocked front end for one elastic latch stage. Round-robin arbitrates
//   REQ_NUM synchronous requesters, registers the winner's rail word onto
//   data_o, then runs one complete lat/ack handshake with the latch before
//   returning to IDLE to accept the next request.
//
//   Encoding (ENC): "TWO_PHASE" toggles lat_o once per transfer; any other
//   value selects four-phase return-to-zero signalling.
//
//   Optional watchdog: define EL_LATCH_CTRL_TIMEOUT_EN to add a wait-cycle
//   counter, the sticky timeout_o flag and a terminal ERR state.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (latch must share it)
//   req_i      level request per requester, held until granted
//   data_i     rail words, requester k at [k*RAIL_NUM +: RAIL_NUM]
//   gnt_o      one-hot single-cycle pulse: word accepted
//   busy_o     high whenever the FSM is not IDLE
//   lat_o      drives the latch lat_i
//   data_o     drives the latch data input, registered
//   ack_i      latch ack_o, asynchronous, synchronised here
//   timeout_o  sticky watchdog flag (EL_LATCH_CTRL_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module el_latch_ctrl #(
  parameter logic [127:0] ENC         = 128'("TWO_PHASE"),
  parameter int           RAIL_NUM    = 2,
  parameter int           REQ_NUM     = 4,
  parameter int           SYNC_STAGES = 2,
  parameter int           TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_NUM-1:0]           req_i,
  input  logic [REQ_NUM*RAIL_NUM-1:0]  data_i,
  output logic [REQ_NUM-1:0]           gnt_o,
  output logic                         busy_o,
  output logic                         lat_o,
  output logic [RAIL_NUM-1:0]          data_o,
  input  logic                         ack_i
`ifdef EL_LATCH_CTRL_TIMEOUT_EN
  ,
  output logic                         timeout_o
`endif
);

  localparam bit IS_TWO_PHASE = (ENC == 128'("TWO_PHASE"));
  localparam int PTR_W        = $clog2(REQ_NUM);

  if (REQ_NUM < 2 || SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_param_check
    $error("el_latch_ctrl: REQ_NUM and SYNC_STAGES must be >= 2, TIMEOUT >= 1");
  end

`ifdef EL_LATCH_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_RTZ, S_ERR} state_e;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
`else
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_RTZ} state_e;
`endif

  state_e                  state_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [PTR_W-1:0]        ptr_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    lat_q;
  logic                    busy_q;
  logic [RAIL_NUM-1:0]     data_q;
  logic [REQ_NUM-1:0]      gnt_q;

  logic                    ack_s;
  logic                    win_vld;
  logic [PTR_W-1:0]        win_idx;
  logic [PTR_W-1:0]        cand;
  logic [RAIL_NUM-1:0]     win_data;

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Round-robin search: scan requesters starting at ptr_q, first hit wins.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise the unassigned paths infer latches.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % REQ_NUM);
      if (!win_vld && req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign ptr_d    = PTR_W'((int'(win_idx) + 1) % REQ_NUM);
  assign win_data = data_i[win_idx*RAIL_NUM +: RAIL_NUM];

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      sync_q    <= '0;
      lat_q     <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      gnt_q     <= '0;
`ifdef EL_LATCH_CTRL_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
      gnt_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            gnt_q   <= REQ_NUM'(1) << win_idx;
            data_q  <= win_data;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        // data_q was loaded one edge earlier, giving the bundled-data setup.
        S_ISSUE: begin
          lat_q   <= IS_TWO_PHASE ? ~lat_q : 1'b1;
          state_q <= S_WAIT_ACK;
`ifdef EL_LATCH_CTRL_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        S_WAIT_ACK: begin
          if (IS_TWO_PHASE ? (ack_s == lat_q) : ack_s) begin
            if (IS_TWO_PHASE) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              lat_q   <= 1'b0;
              state_q <= S_WAIT_RTZ;
`ifdef EL_LATCH_CTRL_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end
          end
`ifdef EL_LATCH_CTRL_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= S_ERR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_WAIT_RTZ: begin
          if (!ack_s) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`ifdef EL_LATCH_CTRL_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= S_ERR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
`ifdef EL_LATCH_CTRL_TIMEOUT_EN
        // Terminal: busy stays high, lat/data frozen, only rst leaves.
        S_ERR: state_q <= S_ERR;
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;
  assign lat_o  = lat_q;
  assign data_o = data_q;
`ifdef EL_LATCH_CTRL_TIMEOUT_EN
  assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_el_latch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_el_latch_ctrl
//   Two controller instances (two-phase and four-phase) share clk/rst. Each
//   has a latch that echoes lat_o onto ack_i after a random delay, random
//   requesters, a transaction-level reference model and a per-cycle compare.
//   Directed sequences add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_el_latch_ctrl;

  localparam int RAIL_NUM    = 2;
  localparam int REQ_NUM     = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 8;
  localparam int DW          = REQ_NUM * RAIL_NUM;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rand_en = 1'b0;
  logic echo_en = 1'b1;
  logic glitch  = 1'b0;
  logic [REQ_NUM-1:0] dir_req  [2] = '{default: '0};
  logic [DW-1:0]      dir_data [2] = '{default: '0};

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  // Rotated-priority pick: requester with smallest distance from p wins.
  function automatic int pick(input logic [REQ_NUM-1:0] r, input int p);
    int best, bd, d;
    best = -1;
    bd   = REQ_NUM;
    for (int k = 0; k < REQ_NUM; k++) begin
      d = (k - p + REQ_NUM) % REQ_NUM;
      if (r[k] && d < bd) begin
        bd   = d;
        best = k;
      end
    end
    return best;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam bit           TWO = (g == 0);
    localparam logic [127:0] ENC = TWO ? 128'("TWO_PHASE") : 128'("FOUR_PHASE");

    logic [REQ_NUM-1:0]  req, gnt;
    logic [REQ_NUM-1:0]  rnd_req = '0;
    logic [DW-1:0]       data;
    logic [DW-1:0]       rnd_data = '0;
    logic                busy, lat, ack, tmo;
    logic                echo_ack = 1'b0;
    logic [RAIL_NUM-1:0] dout;

    assign req  = rand_en ? rnd_req  : dir_req[g];
    assign data = rand_en ? rnd_data : dir_data[g];
    assign ack  = echo_ack ^ glitch;

    el_latch_ctrl #(
      .ENC(ENC), .RAIL_NUM(RAIL_NUM), .REQ_NUM(REQ_NUM),
      .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
    ) u_dut (
      .clk(clk), .rst(rst), .req_i(req), .data_i(data), .gnt_o(gnt),
      .busy_o(busy), .lat_o(lat), .data_o(dout), .ack_i(ack)
`ifdef EL_LATCH_CTRL_TIMEOUT_EN
      , .timeout_o(tmo)
`endif
    );
`ifndef EL_LATCH_CTRL_TIMEOUT_EN
    assign tmo = 1'b0;
`endif

    // Latch: ack follows the lat level 1..4 cycles later; shares rst.
    logic pend = 1'b0;
    int   pend_cnt = 0;
    always @(negedge clk) begin
      if (rst) begin
        echo_ack = 1'b0;
        pend     = 1'b0;
      end else if (echo_en) begin
        if (pend) begin
          if (pend_cnt == 0) begin
            echo_ack = lat;
            pend     = 1'b0;
          end else pend_cnt--;
        end else if (lat != echo_ack) begin
          pend     = 1'b1;
          pend_cnt = $urandom_range(0, 3);
        end
      end
    end

    // Random requesters: hold until granted, occasionally withdraw.
    always @(negedge clk) begin
      if (rand_en) begin
        for (int k = 0; k < REQ_NUM; k++) begin
          if (rnd_req[k] && gnt[k]) rnd_req[k] = 1'b0;
          else if (!rnd_req[k] && $urandom_range(0, 5) == 0) begin
            rnd_req[k] = 1'b1;
            rnd_data[k*RAIL_NUM +: RAIL_NUM] = RAIL_NUM'($urandom);
          end else if (rnd_req[k] && $urandom_range(0, 63) == 0) rnd_req[k] = 1'b0;
        end
      end
    end

    // Grant log.
    logic [REQ_NUM-1:0] glog [64];
    int gtot = 0;
    always @(negedge clk) begin
      if (gnt != '0) begin
        glog[gtot % 64] = gnt;
        gtot++;
      end
    end

    // Reference model: a transfer is outstanding from grant until the
    // synchronised ack level equals the driven lat level; four-phase adds
    // a return-to-zero leg after the rising acknowledge.
    logic [REQ_NUM-1:0]     m_gnt = '0;
    logic                   m_busy = 1'b0, m_lat = 1'b0, m_issue = 1'b0;
    logic                   m_err = 1'b0, m_to = 1'b0;
    logic [RAIL_NUM-1:0]    m_data = '0;
    logic [SYNC_STAGES-1:0] m_hist = '0;
    int                     m_ptr = 0, m_cnt = 0;

    always @(posedge clk) begin : model
      logic ack_s;
      int   w;
      ack_s = m_hist[SYNC_STAGES-1];
      if (rst) begin
        m_gnt = '0; m_busy = 1'b0; m_lat = 1'b0; m_issue = 1'b0;
        m_err = 1'b0; m_to = 1'b0; m_data = '0; m_hist = '0;
        m_ptr = 0; m_cnt = 0;
      end else begin
        m_hist = {m_hist[SYNC_STAGES-2:0], ack};
        m_gnt  = '0;
        if (m_err) begin
          m_busy = 1'b1;
        end else if (!m_busy) begin
          w = pick(req, m_ptr);
          if (w >= 0) begin
            m_gnt[w] = 1'b1;
            m_data   = data[w*RAIL_NUM +: RAIL_NUM];
            m_ptr    = (w + 1) % REQ_NUM;
            m_busy   = 1'b1;
            m_issue  = 1'b1;
          end
        end else if (m_issue) begin
          m_issue = 1'b0;
          m_lat   = TWO ? ~m_lat : 1'b1;
          m_cnt   = 0;
        end else if (ack_s == m_lat) begin
          if (!TWO && m_lat) begin
            m_lat = 1'b0;
            m_cnt = 0;
          end else m_busy = 1'b0;
        end else begin
`ifdef EL_LATCH_CTRL_TIMEOUT_EN
          if (m_cnt == TIMEOUT - 1) begin
            m_err = 1'b1;
            m_to  = 1'b1;
          end else m_cnt++;
`endif
        end
      end
    end

    always @(negedge clk) begin
      check("gnt", g, gnt, m_gnt);
      check("gnt_onehot", g, ($countones(gnt) <= 1), 1);
      check("busy", g, busy, m_busy);
      check("lat", g, lat, m_lat);
      check("data_o", g, dout, m_data);
      check("timeout", g, tmo, m_to);
    end
  end

  function automatic logic get_busy(input int g);
    return (g == 0) ? g_env[0].busy : g_env[1].busy;
  endfunction
  function automatic logic get_lat(input int g);
    return (g == 0) ? g_env[0].lat : g_env[1].lat;
  endfunction
  function automatic logic get_tmo(input int g);
    return (g == 0) ? g_env[0].tmo : g_env[1].tmo;
  endfunction
  function automatic logic [RAIL_NUM-1:0] get_dout(input int g);
    return (g == 0) ? g_env[0].dout : g_env[1].dout;
  endfunction
  function automatic logic [REQ_NUM-1:0] get_gnt(input int g);
    return (g == 0) ? g_env[0].gnt : g_env[1].gnt;
  endfunction
  function automatic int get_gtot(input int g);
    return (g == 0) ? g_env[0].gtot : g_env[1].gtot;
  endfunction
  function automatic logic [REQ_NUM-1:0] get_glog(input int g, input int i);
    return (g == 0) ? g_env[0].glog[i % 64] : g_env[1].glog[i % 64];
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // One request per instance; drop it once granted, finish when idle again.
  task automatic xfer(input logic [REQ_NUM-1:0] r, input logic [DW-1:0] d,
                      input logic [REQ_NUM-1:0] exp_gnt, input string tag);
    int n0 [2];
    bit done [2];
    for (int g = 0; g < 2; g++) begin
      n0[g] = get_gtot(g); done[g] = 1'b0; dir_req[g] = r; dir_data[g] = d;
    end
    for (int c = 0; c < 80 && !(done[0] && done[1]); c++) begin
      cyc();
      for (int g = 0; g < 2; g++) begin
        if (dir_req[g] != '0 && get_gtot(g) != n0[g]) dir_req[g] = '0;
        else if (dir_req[g] == '0 && !get_busy(g)) done[g] = 1'b1;
      end
    end
    for (int g = 0; g < 2; g++) begin
      dir_req[g] = '0;
      check({tag, "_done"}, g, done[g], 1);
      check({tag, "_grant"}, g, get_glog(g, get_gtot(g) - 1), exp_gnt);
    end
  endtask

  initial begin
    int n0 [2];
    logic lat0 [2];
    bit ok;

    rst = 1'b1;
    repeat (3) cyc();
    for (int g = 0; g < 2; g++) begin
      check("rst_lat", g, get_lat(g), 0);
      check("rst_busy", g, get_busy(g), 0);
      check("rst_data", g, get_dout(g), 0);
      check("rst_gnt", g, get_gnt(g), 0);
    end
    rst = 1'b0;
    cyc();

    // Single transfers from requester 0.
    xfer(4'b0001, 8'h02, 4'b0001, "t1a");
    for (int g = 0; g < 2; g++) check("t1a_data", g, get_dout(g), 2'b10);
    check("t1a_lat_two", 0, get_lat(0), 1);
    check("t1a_lat_four", 1, get_lat(1), 0);
    xfer(4'b0001, 8'h01, 4'b0001, "t1b");
    check("t1b_lat_two", 0, get_lat(0), 0);
    check("t1b_data", 1, get_dout(1), 2'b01);

    // ack glitch straddling a clock edge while idle, no requests.
    for (int g = 0; g < 2; g++) begin lat0[g] = get_lat(g); n0[g] = get_gtot(g); end
    #3 glitch = 1'b1;
    @(posedge clk);
    #2 glitch = 1'b0;
    repeat (6) cyc();
    for (int g = 0; g < 2; g++) begin
      check("t6_busy", g, get_busy(g), 0);
      check("t6_lat", g, get_lat(g), lat0[g]);
      check("t6_gtot", g, get_gtot(g), n0[g]);
    end

    // All four requesting: strict rotation from requester 0.
    pulse_rst();
    for (int g = 0; g < 2; g++) begin
      n0[g] = get_gtot(g); dir_req[g] = 4'b1111; dir_data[g] = 8'b11_10_01_00;
    end
    for (int c = 0; c < 200 && (dir_req[0] != '0 || dir_req[1] != '0); c++) begin
      cyc();
      for (int g = 0; g < 2; g++)
        if (get_gtot(g) >= n0[g] + 5) dir_req[g] = '0;
    end
    for (int g = 0; g < 2; g++) begin
      check("t2_finished", g, dir_req[g], 0);
      dir_req[g] = '0;
      check("t2_g0", g, get_glog(g, n0[g] + 0), 4'b0001);
      check("t2_g1", g, get_glog(g, n0[g] + 1), 4'b0010);
      check("t2_g2", g, get_glog(g, n0[g] + 2), 4'b0100);
      check("t2_g3", g, get_glog(g, n0[g] + 3), 4'b1000);
      check("t2_g4", g, get_glog(g, n0[g] + 4), 4'b0001);
      check("t2_data", g, get_dout(g), 2'b00);
    end
    repeat (20) cyc();

    // Reset in the middle of a handshake with lat high.
    pulse_rst();
    echo_en = 1'b0;
    for (int g = 0; g < 2; g++) begin
      n0[g] = get_gtot(g); dir_req[g] = 4'b0001; dir_data[g] = 8'h03;
    end
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      cyc();
      for (int g = 0; g < 2; g++) if (get_gtot(g) != n0[g]) dir_req[g] = '0;
      ok = get_lat(0) && get_lat(1);
    end
    check("t4_lat_high", 0, ok, 1);
    cyc();
    pulse_rst();
    for (int g = 0; g < 2; g++) begin
      check("t4_lat", g, get_lat(g), 0);
      check("t4_busy", g, get_busy(g), 0);
      check("t4_data", g, get_dout(g), 0);
    end
    echo_en = 1'b1;
    xfer(4'b0011, 8'h06, 4'b0001, "t4_ptr0");
    xfer(4'b0010, 8'h0C, 4'b0010, "t4_req1");

    // Random traffic with random ack latency.
    rand_en = 1'b1;
    repeat (3000) cyc();
    rand_en = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      cyc();
      ok = !get_busy(0) && !get_busy(1);
    end
    check("rand_drain", 0, ok, 1);

`ifdef EL_LATCH_CTRL_TIMEOUT_EN
    // Watchdog: ack never returns.
    begin
      int t_lat [2];
      int t_to [2];
      pulse_rst();
      echo_en = 1'b0;
      for (int g = 0; g < 2; g++) begin
        n0[g] = get_gtot(g); dir_req[g] = 4'b0001; t_lat[g] = -1; t_to[g] = -1;
      end
      for (int c = 0; c < 40; c++) begin
        cyc();
        for (int g = 0; g < 2; g++) begin
          if (get_gtot(g) != n0[g]) dir_req[g] = '0;
          if (t_lat[g] < 0 && get_lat(g)) t_lat[g] = c;
          if (t_to[g] < 0 && get_tmo(g)) t_to[g] = c;
        end
      end
      for (int g = 0; g < 2; g++) begin
        check("t5_seen", g, (t_lat[g] >= 0 && t_to[g] >= 0), 1);
        check("t5_delay", g, t_to[g] - t_lat[g], TIMEOUT);
        n0[g] = get_gtot(g); dir_req[g] = 4'b1111;
      end
      repeat (20) cyc();
      for (int g = 0; g < 2; g++) begin
        check("t5_no_gnt", g, get_gtot(g), n0[g]);
        check("t5_busy", g, get_busy(g), 1);
        dir_req[g] = '0;
      end
      pulse_rst();
      for (int g = 0; g < 2; g++) begin
        check("t5_rst_tmo", g, get_tmo(g), 0);
        check("t5_rst_busy", g, get_busy(g), 0);
      end
      echo_en = 1'b1;
    end
`endif

    repeat (5) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
